debounce_multi: RTL
===================

// Module: debounce_multi
// PURPOSE
//   Parametrised multi-channel debouncer for the board's mechanical switches/buttons.
//   Each channel has its own 2-flop synchroniser, 4-state FSM and N-bit filter counter.
//   Outputs: a stable level, registered rise/fall pulses, and an optional auto-repeat pulse.
//   Sits between the board pins and the control FSMs, replacing one-instance-per-switch use.
// PARAMETERS
//   CH     4   number of independent channels (>=1)
//   N      20  filter counter width; stable time ~2^N cycles (20 => ~10 ms @100 MHz; 2 for sim)
//   RPT_N  24  auto-repeat period = 2^RPT_N cycles (used only with DEBOUNCE_REPEAT_EN)
// PORTS
//   clk        in   1   system clock (100 MHz)
//   reset      in   1   asynchronous, active-high reset
//   sw         in   CH  raw asynchronous switch inputs
//   db_level   out  CH  debounced level per channel
//   db_rise    out  CH  1-cycle pulse on debounced 0->1
//   db_fall    out  CH  1-cycle pulse on debounced 1->0
//   db_repeat  out  CH  1-cycle auto-repeat pulse while held (0 when feature off)
//   any_change out  1   OR over all channels of (db_rise | db_fall)
// BEHAVIOUR
//   - Reset (async, immediate): sync flops, counters, pulses = 0; all FSMs in ZERO;
//     every output 0. Reset mid-filter discards the pending transition; no pulse on release.
//   - Sync: s1 <= sw; s2 <= s1 per channel; FSM sees only s2.
//   - FSM per channel: ZERO, WAIT1, ONE, WAIT0. db_level = 1 in ONE and WAIT0, else 0.
//   - ZERO:  s2=1 -> WAIT1, counter loads all-ones (2^N-1).
//   - WAIT1: s2=1 -> counter decrements; if the next value is 0 -> ONE. s2=0 -> ZERO, no pulse.
//   - ONE:   s2=0 -> WAIT0, counter loads all-ones.
//   - WAIT0: s2=0 -> counter decrements; if the next value is 0 -> ZERO. s2=1 -> ONE, no pulse.
//   - Counter holds in ZERO/ONE. Arithmetic is unsigned N-bit. No wrap is possible,
//     because load and exit both happen before 0 is reached.
//   - Latency: sw first sampled high at edge e0, held stable -> db_level rises at edge
//     e0 + 2^N + 1 (N=2: e0+5). The 1->0 direction is symmetric.
//   - db_rise/db_fall are registered and high for exactly the first cycle db_level is in
//     its new value. They are never both high on one channel. Channels are fully independent;
//     simultaneous events on several channels produce simultaneous pulses.
//   - any_change is combinational from the registered pulse flops and aligned with them.
// CONFIGURATION
//   `DEBOUNCE_REPEAT_EN defined:
//     - A per-channel RPT_N-bit counter is cleared on entry to ONE and increments in ONE/WAIT0.
//     - On each wrap to 0, db_repeat pulses for 1 cycle (first pulse 2^RPT_N cycles after db_rise,
//       then periodic). It is cleared and paused in ZERO/WAIT1.
//     - A WAIT0 bounce back to ONE does not clear it.
//   Not defined: no repeat counters are synthesised; db_repeat is tied to 0; the port is kept.
// TESTING (N=2, RPT_N=3, CH=4)
//   1. Reset asserted then released, sw=0 -> all outputs 0 for 20 cycles.
//   2. sw[0] 0->1, held -> db_level[0]=1 at e0+5; db_rise[0] and any_change high exactly at that edge.
//   3. sw[1] high for 3 cycles then low -> db_level[1] and db_rise[1] stay 0; FSM returns to ZERO.
//   4. sw[2] held, then released with a 2-cycle bounce -> one db_fall[2] only, 5 cycles after
//      the final stable low; no second db_rise.
//   5. sw[3:0]=4'b1111 in one cycle -> all db_rise bits pulse on the same edge; reset
//      mid-WAIT1 -> no pulse, level 0.
//   6. REPEAT_EN, sw[0] held 40 cycles -> db_repeat[0] at 8, 16, 24, 32 cycles after db_rise[0];
//      without the macro, db_repeat stays 0.

Source files
------------

// File: rtl/debounce_multi_if.sv
// Signal bundle between the raw switch pins and the debouncer outputs.
// The slave side is the debouncer; dbg_state exposes each channel's FSM state, 2 bits per channel.
interface debounce_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   sw;
  logic [CH-1:0]   db_level;
  logic [CH-1:0]   db_rise;
  logic [CH-1:0]   db_fall;
  logic [CH-1:0]   db_repeat;
  logic            any_change;
  logic [2*CH-1:0] dbg_state;

  modport master (
    output sw,
    input  db_level, db_rise, db_fall, db_repeat, any_change, dbg_state
  );

  modport slave (
    input  sw,
    output db_level, db_rise, db_fall, db_repeat, any_change, dbg_state
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel 2-flop sync, 4-state filter FSM, rise/fall pulses.
// Optional auto-repeat while held is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi #(
  parameter int CH    = 4,
  parameter int N     = 20,
  parameter int RPT_N = 24
) (
  input  logic                clk,
  input  logic                reset,
  debounce_multi_if.slave     db
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [CH-1:0] s1_q, s2_q;
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [N-1:0]  cnt_q   [CH];
  logic [N-1:0]  cnt_d   [CH];
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;
  logic [CH-1:0] level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q   <= db.sw;
      s2_q   <= s1_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Leaving a WAIT state is decided on the current count so the counter never wraps.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      case (state_q[i])
        ZERO: begin
          if (s2_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '1;
          end
        end
        WAIT1: begin
          if (s2_q[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] == N'(1)) begin
              state_d[i] = ONE;
              rise_d[i]  = 1'b1;
            end
          end else begin
            state_d[i] = ZERO;
          end
        end
        ONE: begin
          if (!s2_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '1;
          end
        end
        WAIT0: begin
          if (!s2_q[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] == N'(1)) begin
              state_d[i] = ZERO;
              fall_d[i]  = 1'b1;
            end
          end else begin
            state_d[i] = ONE;
          end
        end
        default: state_d[i] = ZERO;
      endcase
    end
  end

  always_comb begin
    level        = '0;
    db.dbg_state = '0;
    for (int i = 0; i < CH; i++) begin
      level[i]             = (state_q[i] == ONE) || (state_q[i] == WAIT0);
      db.dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign db.db_level   = level;
  assign db.db_rise    = rise_q;
  assign db.db_fall    = fall_q;
  assign db.any_change = |(rise_q | fall_q);

`ifdef DEBOUNCE_REPEAT_EN
  logic [RPT_N-1:0] rcnt_q [CH];
  logic [RPT_N-1:0] rcnt_d [CH];
  logic [CH-1:0]    rpt_q, rpt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
      for (int i = 0; i < CH; i++) rcnt_q[i] <= '0;
    end else begin
      rpt_q <= rpt_d;
      for (int i = 0; i < CH; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  // Counter runs only while held; a pulse is suppressed when the channel is just dropping out.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      rcnt_d[i] = '0;
      rpt_d[i]  = 1'b0;
      if (level[i]) begin
        rcnt_d[i] = rcnt_q[i] + 1'b1;
        rpt_d[i]  = (rcnt_q[i] == '1) &&
                    ((state_d[i] == ONE) || (state_d[i] == WAIT0));
      end
    end
  end

  assign db.db_repeat = rpt_q;
`else
  // RPT_N has no hardware in this build; the comparison is constant zero.
  assign db.db_repeat = {CH{RPT_N < 0}};
`endif

endmodule
